axis_data_chk: RTL
==================

Name: axis_data_chk

Overview:
AXI-Stream sink and checker. It is the receive-side counterpart of the team's AXI-Stream data generator. It consumes a frame from the PS/DMA loopback master port, then checks the incrementing data pattern, keep and frame length. Errors and counts are reported for GPIO readback and interrupt. It sits in top on the axis_clk domain, driven by a GPIO rising-edge start pulse.

Parameters:
DATA_WIDTH, 64, tdata width in bits; multiple of 8
LENGTH_WIDTH, 9, width of i_length; frame length in beats
ERR_CNT_WIDTH, 16, width of o_err_cnt and o_beat_cnt

Ports:
clk  input  1  stream clock (axis_clk)
arstn  input  1  asynchronous active-low reset
i_start  input  1  one-cycle pulse; arms a frame check
i_length  input  LENGTH_WIDTH  expected beats; 0 means 2^LENGTH_WIDTH; sampled on accepted i_start
i_data  input  DATA_WIDTH  tdata
i_valid  input  1  tvalid
i_keep  input  DATA_WIDTH/8  tkeep
i_last  input  1  tlast
o_ready  output  1  tready
o_busy  output  1  high in RECV or DRAIN
o_done  output  1  one-cycle pulse at frame end
o_err  output  4  sticky flags: [0] data mismatch, [1] short frame, [2] long frame, [3] keep error
o_err_cnt  output  ERR_CNT_WIDTH  mismatching beats, saturating
o_beat_cnt  output  ERR_CNT_WIDTH  beats accepted in frame, saturating

Behaviour:
- Reset (arstn low, async assert; deassert sync to clk): state IDLE; all outputs 0; internal expected word and counters 0.
- Handshake: a beat is accepted when i_valid && o_ready on a rising clk edge. o_ready is combinational from state only, never from i_valid.
- State IDLE:
  - o_ready=0.
  - i_start=1 → RECV. Latch the length, clear o_err, o_err_cnt and o_beat_cnt, set expected=0.
- State RECV:
  - o_ready=1.
  - Per accepted beat k (0-based): the expected word is k zero-extended to DATA_WIDTH.
  - i_data != expected → set o_err[0] and increment o_err_cnt (saturate at all-ones).
  - i_keep != all-ones → set o_err[3].
  - o_beat_cnt increments per beat, saturating. Expected increments, wrapping modulo 2^DATA_WIDTH.
  - i_last=1 on beat k < L-1 → set o_err[1] → DONE.
  - Beat k = L-1 with i_last=1 → DONE, no length error.
  - Beat k = L-1 with i_last=0 → set o_err[2] → DRAIN.
- State DRAIN:
  - o_ready=1; beats are counted in o_beat_cnt but not data-checked.
  - First accepted i_last → DONE.
- State DONE:
  - o_ready=0; o_done=1 for exactly one cycle → IDLE.
  - o_err and counts hold until the next accepted start.
- Latency: o_done rises on the clock after the i_last beat handshake.
- i_start outside IDLE (including DONE) is ignored. No queuing.
- Data checking sees the beat only when the handshake occurs; idle cycles with i_valid=0 change nothing.
- arstn asserted mid-frame → immediate IDLE. No o_done is produced for the aborted frame.

Optional Feature:
- Macro AXIS_CHK_BP_EN.
- Defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 0xACE1 at reset), advanced every clk. In RECV/DRAIN, o_ready = lfsr[0] | lfsr[1], i.e. about 75% duty, to exercise backpressure. Check results and counts must be identical to the non-BP build for the same frame.
- Undefined: no LFSR; o_ready is always 1 in RECV/DRAIN.

Test Plan:
- Good frame: start, L=0x80, data 0..0x7F, i_last on beat 0x7F, continuous valid → o_done at cycle after last handshake; o_err=0, o_beat_cnt=0x80, o_err_cnt=0.
- Data corruption: L=16, beat 5 sent as 0xDEAD, beat 9 as 0 → o_err=4'b0001, o_err_cnt=2, o_beat_cnt=16.
- Short/long frames:
  - L=16 with i_last on beat 9 → o_err[1]=1, o_beat_cnt=10.
  - L=16 with i_last on beat 19 → o_err[2]=1, o_beat_cnt=20, o_done only after beat 19.
- Gaps and keep: L=8 with i_valid toggled every other cycle, beat 3 keep=0x0F → o_err=4'b1000, o_beat_cnt=8. A second i_start during RECV is ignored.
- Reset and wrap: arstn low at beat 4 of L=32 → all outputs 0 and no o_done. i_length=0 → 512 beats accepted error-free with i_last on beat 511.
- With AXIS_CHK_BP_EN: repeat the good-frame test → o_ready observed low at least once; results identical to the first scenario.

Source files
------------

// File: rtl/axis_data_chk.sv
// axis_data_chk: AXI-Stream sink that checks an incrementing data pattern, tkeep and frame length.
// Optional feature macro AXIS_CHK_BP_EN: LFSR-driven pseudo-random backpressure on o_ready.
module axis_data_chk #(
   parameter int DATA_WIDTH    = 64,
   parameter int LENGTH_WIDTH  = 9,
   parameter int ERR_CNT_WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     arstn,
   input  logic                     i_start,
   input  logic [LENGTH_WIDTH-1:0]  i_length,
   input  logic [DATA_WIDTH-1:0]    i_data,
   input  logic                     i_valid,
   input  logic [DATA_WIDTH/8-1:0]  i_keep,
   input  logic                     i_last,
   output logic                     o_ready,
   output logic                     o_busy,
   output logic                     o_done,
   output logic [3:0]               o_err,
   output logic [ERR_CNT_WIDTH-1:0] o_err_cnt,
   output logic [ERR_CNT_WIDTH-1:0] o_beat_cnt
);
   typedef enum logic [1:0] {IDLE, RECV, DRAIN, DONE} state_t;
   state_t state, state_nxt;
   logic [LENGTH_WIDTH-1:0] len, len_m1;
   logic [DATA_WIDTH-1:0]   expected;
   logic accept, last_idx, bp_ok;
`ifdef AXIS_CHK_BP_EN
   logic [15:0] lfsr;
   // free-running Fibonacci LFSR (taps 16,14,13,11) throttling o_ready
   always_ff @(posedge clk or negedge arstn)
      if (!arstn) lfsr <= 16'hACE1;
      else lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   assign bp_ok = lfsr[0] | lfsr[1];
`else
   assign bp_ok = 1'b1;
`endif
   assign o_ready  = (state == RECV || state == DRAIN) && bp_ok;
   assign o_busy   = state == RECV || state == DRAIN;
   assign o_done   = state == DONE;
   assign accept   = i_valid && o_ready;
   assign len_m1   = len - LENGTH_WIDTH'(1);
   assign last_idx = expected == DATA_WIDTH'(len_m1);
   // state register
   always_ff @(posedge clk or negedge arstn)
      if (!arstn) state <= IDLE;
      else state <= state_nxt;
   // next-state: RECV ends on tlast or on the final expected beat; DRAIN ends on tlast
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  state_nxt = i_start ? RECV : IDLE;
         RECV:  if (accept && (i_last || last_idx)) state_nxt = i_last ? DONE : DRAIN;
         DRAIN: if (accept && i_last) state_nxt = DONE;
         default: state_nxt = IDLE;
      endcase
   end
   // frame bookkeeping: cleared on accepted start, updated per accepted beat
   always_ff @(posedge clk or negedge arstn)
      if (!arstn) begin
         len        <= '0;
         expected   <= '0;
         o_err      <= '0;
         o_err_cnt  <= '0;
         o_beat_cnt <= '0;
      end else if (state == IDLE && i_start) begin
         len        <= i_length;
         expected   <= '0;
         o_err      <= '0;
         o_err_cnt  <= '0;
         o_beat_cnt <= '0;
      end else if (accept) begin
         o_beat_cnt <= o_beat_cnt + ERR_CNT_WIDTH'(~&o_beat_cnt);
         if (state == RECV) begin
            expected <= expected + DATA_WIDTH'(1);
            if (i_data != expected) begin
               o_err[0]  <= 1'b1;
               o_err_cnt <= o_err_cnt + ERR_CNT_WIDTH'(~&o_err_cnt);
            end
            if (!(&i_keep)) o_err[3] <= 1'b1;
            if (i_last && !last_idx) o_err[1] <= 1'b1;
            if (last_idx && !i_last) o_err[2] <= 1'b1;
         end
      end
endmodule
